dtl_master_interface: RTL and testbench
=======================================

Name: dtl_master_interface

Overview:
- Upstream DTL initiator for the CGRA memory-mapped slave port.
- Converts a local request (address, direction, burst length) into one DTL transaction: a command phase, then a write-data burst or a read-data burst.
- Drives the DTL command/write/read channels consumed by the DTL slave interface.
- Gives the local side simple valid/accept streams for write and read data.

Parameters:
INTERFACE_WIDTH, 32, data word width in bits
INTERFACE_ADDR_WIDTH, 32, byte address width
INTERFACE_BLOCK_WIDTH, 5, burst length field width (value = beats-1)
INTERFACE_NUM_ENABLES, INTERFACE_WIDTH/8, byte enables per word

Ports:
iClk  in  1  clock
iReset  in  1  synchronous, active-high reset
iReqValid  in  1  local transaction request
oReqAccept  out  1  request accepted (high only in IDLE)
iReqReadWrite  in  1  1=read, 0=write
iReqAddress  in  ADDR_WIDTH  start byte address
iReqBlockSize  in  BLOCK_WIDTH  beats-1
iWrValid  in  1  local write word valid
oWrAccept  out  1  local write word taken
iWrData  in  WIDTH  local write word
iWrEnable  in  NUM_ENABLES  local byte enables
oRdValid  out  1  read word valid to local side
iRdAccept  in  1  local side takes read word
oRdData  out  WIDTH  read word
oRdLast  out  1  final read word of burst
oBusy  out  1  state != IDLE
oDone  out  1  one-cycle pulse at transaction completion
oDTL_CommandValid  out  1  DTL command valid
iDTL_CommandAccept  in  1  DTL command accepted
oDTL_Address  out  ADDR_WIDTH  DTL address
oDTL_CommandReadWrite  out  1  DTL direction, 1=read
oDTL_BlockSize  out  BLOCK_WIDTH  DTL burst length
oDTL_WriteValid  out  1  DTL write word valid
oDTL_WriteLast  out  1  DTL final write word
iDTL_WriteAccept  in  1  DTL write word accepted
oDTL_WriteEnable  out  NUM_ENABLES  DTL byte enables
oDTL_WriteData  out  WIDTH  DTL write word
iDTL_ReadValid  in  1  DTL read word valid
iDTL_ReadLast  in  1  DTL final read word
oDTL_ReadAccept  out  1  DTL read word accepted
iDTL_ReadData  in  WIDTH  DTL read word

Behaviour:
- States: IDLE, CMD, WRITE, READ.
- Reset (iReset sampled high; takes effect at the next edge, from any state, mid-burst included):
  - state=IDLE; beat counter=0; write holding register empty.
  - oDTL_CommandValid=0, oDTL_WriteValid=0, oDTL_WriteLast=0, oDone=0.
  - oDTL_Address, oDTL_BlockSize, oDTL_WriteData and oDTL_WriteEnable = 0.
  - Error flag cleared (when compiled in).
  - No completion pulse for the aborted transaction.
- IDLE:
  - oReqAccept=1.
  - On iReqValid: register address, size and direction onto the oDTL_* command fields; load beat counter = iReqBlockSize.
  - Next cycle: oDTL_CommandValid=1, state=CMD.
- CMD:
  - Command fields held stable while oDTL_CommandValid=1.
  - On iDTL_CommandAccept: CommandValid drops next cycle; state goes to WRITE or READ per direction.
- WRITE:
  - One-entry holding register drives oDTL_WriteValid, WriteData and WriteEnable.
  - oWrAccept = holding empty, or holding drains this cycle (WriteValid & WriteAccept), AND words-not-yet-loaded > 0. This accept is combinational.
  - On iWrValid & oWrAccept: word loads into the holding register; WriteValid=1 next cycle.
  - oDTL_WriteLast=1 exactly when the held word is beat number BlockSize (the last one).
  - Each DTL handshake decrements the beat counter.
  - Last-word handshake: WriteValid/WriteLast drop; oDone pulses; state=IDLE.
  - Local gaps on iWrValid produce DTL WriteValid gaps. Data is never reordered or dropped.
- READ:
  - oDTL_ReadAccept = iRdAccept.
  - oRdValid = iDTL_ReadValid; oRdData = iDTL_ReadData. Pure combinational pass-through, zero latency.
  - oRdLast = (beat counter == 0).
  - Each handshake decrements the counter.
  - Counter==0 handshake: oDone pulses next cycle; state=IDLE.
  - oRdValid=0 and oDTL_ReadAccept=0 outside READ.
- Timing:
  - Earliest new request: the cycle after oDone (one IDLE cycle between transactions).
  - Request-to-CommandValid latency: 1 cycle.
- Width rules:
  - BlockSize=0 means one beat; maximum is 2^BLOCK_WIDTH beats.
  - The master never increments the address (the slave does); oDTL_Address is held for the whole transaction.
- Boundary: iReqValid outside IDLE is ignored (oReqAccept=0).

Optional Feature:
- Macro DTL_MASTER_LASTCHECK_EN.
- With it: extra output oProtocolError, 1 bit, sticky, reset 0. Set when a read handshake has iDTL_ReadLast different from (counter==0), or when iDTL_WriteAccept is seen while oDTL_WriteValid=0. Cleared only by iReset.
- Without it: port absent; iDTL_ReadLast unused; completion is decided by the counter only.

Test Plan:
1. Write, addr 0x100, size 0, data 0xDEADBEEF, en 0xF → CommandValid one cycle after request; one DTL beat with WriteLast=1; oDone pulses once; oBusy low the next cycle.
2. Write, size 3, iWrValid gaps on beats 1 and 2, iDTL_WriteAccept stalled 2 cycles on beat 0 → DTL sees exactly 4 beats, in order, data intact; WriteLast only on beat 3.
3. Read, addr 0x40, size 2, slave data 0x1, 0x2, 0x3, iRdAccept low for 3 cycles mid-burst → oRdData in order 1, 2, 3; oRdLast only on 0x3; oDone after the third handshake.
4. Read size 0, then a write request one cycle after oDone → second command issued with ReadWrite=0; no overlap of ReadAccept and WriteValid.
5. iReset asserted mid write burst (beat 2 of 4) → next cycle all DTL valids=0, oBusy=0, no oDone; a fresh request works normally.
6. With DTL_MASTER_LASTCHECK_EN: read size 3, slave asserts ReadLast on beat 1 → oProtocolError=1 and stays 1 until reset.

Source files
------------

// File: rtl/dtl_master_interface.sv
// DTL initiator: turns one local request into a DTL command followed by a write or read burst.
// Optional build macro DTL_MASTER_LASTCHECK_EN adds the sticky oProtocolError output.
//
// state | meaning
// IDLE  | waiting for a local request
// CMD   | command presented on DTL, waiting for accept
// WRITE | write burst through the one-entry holding register
// READ  | read burst, combinational pass-through to the local side
module dtl_master_interface #(
    parameter int INTERFACE_WIDTH       = 32,
    parameter int INTERFACE_ADDR_WIDTH  = 32,
    parameter int INTERFACE_BLOCK_WIDTH = 5,
    parameter int INTERFACE_NUM_ENABLES = INTERFACE_WIDTH / 8
) (
    input  logic                             iClk,
    input  logic                             iReset,
    input  logic                             iReqValid,
    output logic                             oReqAccept,
    input  logic                             iReqReadWrite,
    input  logic [INTERFACE_ADDR_WIDTH-1:0]  iReqAddress,
    input  logic [INTERFACE_BLOCK_WIDTH-1:0] iReqBlockSize,
    input  logic                             iWrValid,
    output logic                             oWrAccept,
    input  logic [INTERFACE_WIDTH-1:0]       iWrData,
    input  logic [INTERFACE_NUM_ENABLES-1:0] iWrEnable,
    output logic                             oRdValid,
    input  logic                             iRdAccept,
    output logic [INTERFACE_WIDTH-1:0]       oRdData,
    output logic                             oRdLast,
    output logic                             oBusy,
    output logic                             oDone,
`ifdef DTL_MASTER_LASTCHECK_EN
    output logic                             oProtocolError,
`endif
    output logic                             oDTL_CommandValid,
    input  logic                             iDTL_CommandAccept,
    output logic [INTERFACE_ADDR_WIDTH-1:0]  oDTL_Address,
    output logic                             oDTL_CommandReadWrite,
    output logic [INTERFACE_BLOCK_WIDTH-1:0] oDTL_BlockSize,
    output logic                             oDTL_WriteValid,
    output logic                             oDTL_WriteLast,
    input  logic                             iDTL_WriteAccept,
    output logic [INTERFACE_NUM_ENABLES-1:0] oDTL_WriteEnable,
    output logic [INTERFACE_WIDTH-1:0]       oDTL_WriteData,
    input  logic                             iDTL_ReadValid,
    input  logic                             iDTL_ReadLast,
    output logic                             oDTL_ReadAccept,
    input  logic [INTERFACE_WIDTH-1:0]       iDTL_ReadData
);

    localparam int BW = INTERFACE_BLOCK_WIDTH;
    localparam logic [BW-1:0] ONE_BEAT = BW'(1);
    localparam logic [BW:0]   ONE_LOAD = (BW + 1)'(1);

    typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;

    state_t        state;
    logic [BW-1:0] beat_cnt;
    logic [BW:0]   load_left;   // words still to be taken from the local side
    logic          wr_load;
    logic          wr_hs;
    logic          rd_hs;

    assign oReqAccept      = (state == IDLE) && !oDone;
    assign oBusy           = (state != IDLE);
    assign oWrAccept       = (state == WRITE) && (!oDTL_WriteValid || iDTL_WriteAccept)
                             && (load_left != '0);
    assign wr_load         = iWrValid && oWrAccept;
    assign wr_hs           = oDTL_WriteValid && iDTL_WriteAccept;
    assign rd_hs           = (state == READ) && iDTL_ReadValid && iRdAccept;
    assign oRdValid        = (state == READ) && iDTL_ReadValid;
    assign oRdData         = iDTL_ReadData;
    assign oRdLast         = (state == READ) && (beat_cnt == '0);
    assign oDTL_ReadAccept = (state == READ) && iRdAccept;

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state                 <= IDLE;
            beat_cnt              <= '0;
            load_left             <= '0;
            oDone                 <= 1'b0;
            oDTL_CommandValid     <= 1'b0;
            oDTL_Address          <= '0;
            oDTL_CommandReadWrite <= 1'b0;
            oDTL_BlockSize        <= '0;
            oDTL_WriteValid       <= 1'b0;
            oDTL_WriteLast        <= 1'b0;
            oDTL_WriteData        <= '0;
            oDTL_WriteEnable      <= '0;
        end else begin
            oDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (iReqValid && oReqAccept) begin
                        oDTL_Address          <= iReqAddress;
                        oDTL_CommandReadWrite <= iReqReadWrite;
                        oDTL_BlockSize        <= iReqBlockSize;
                        oDTL_CommandValid     <= 1'b1;
                        beat_cnt              <= iReqBlockSize;
                        load_left             <= {1'b0, iReqBlockSize} + ONE_LOAD;
                        state                 <= CMD;
                    end
                end
                CMD: begin
                    if (iDTL_CommandAccept) begin
                        oDTL_CommandValid <= 1'b0;
                        state             <= oDTL_CommandReadWrite ? READ : WRITE;
                    end
                end
                WRITE: begin
                    if (wr_hs) begin
                        beat_cnt <= beat_cnt - ONE_BEAT;
                    end
                    // a load in the same cycle as a drain simply replaces the held word
                    if (wr_load) begin
                        oDTL_WriteData   <= iWrData;
                        oDTL_WriteEnable <= iWrEnable;
                        oDTL_WriteValid  <= 1'b1;
                        oDTL_WriteLast   <= (load_left == ONE_LOAD);
                        load_left        <= load_left - ONE_LOAD;
                    end else if (wr_hs) begin
                        oDTL_WriteValid <= 1'b0;
                        oDTL_WriteLast  <= 1'b0;
                    end
                    if (wr_hs && oDTL_WriteLast) begin
                        oDone <= 1'b1;
                        state <= IDLE;
                    end
                end
                READ: begin
                    if (rd_hs) begin
                        beat_cnt <= beat_cnt - ONE_BEAT;
                        if (beat_cnt == '0) begin
                            oDone <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DTL_MASTER_LASTCHECK_EN
    always_ff @(posedge iClk) begin
        if (iReset) begin
            oProtocolError <= 1'b0;
        end else if ((rd_hs && (iDTL_ReadLast != (beat_cnt == '0)))
                     || (iDTL_WriteAccept && !oDTL_WriteValid)) begin
            oProtocolError <= 1'b1;
        end
    end
`else
    // completion is counter-driven; the slave's last flag is not needed
    logic unused_read_last;
    assign unused_read_last = iDTL_ReadLast;
`endif

endmodule

// File: tb/tb_dtl_master_interface.sv
// Randomized scoreboard bench for dtl_master_interface; expected DTL/local streams come
// from transaction-level queues filled when each request is issued.
module tb_dtl_master_interface;
    localparam int W  = 32;
    localparam int AW = 32;
    localparam int BW = 5;
    localparam int NE = W / 8;

    logic          iClk = 1'b0;
    logic          iReset;
    logic          iReqValid, oReqAccept, iReqReadWrite;
    logic [AW-1:0] iReqAddress;
    logic [BW-1:0] iReqBlockSize;
    logic          iWrValid, oWrAccept;
    logic [W-1:0]  iWrData;
    logic [NE-1:0] iWrEnable;
    logic          oRdValid, iRdAccept, oRdLast, oBusy, oDone;
    logic [W-1:0]  oRdData;
    logic          oDTL_CommandValid, iDTL_CommandAccept, oDTL_CommandReadWrite;
    logic [AW-1:0] oDTL_Address;
    logic [BW-1:0] oDTL_BlockSize;
    logic          oDTL_WriteValid, oDTL_WriteLast, iDTL_WriteAccept;
    logic [NE-1:0] oDTL_WriteEnable;
    logic [W-1:0]  oDTL_WriteData;
    logic          iDTL_ReadValid, iDTL_ReadLast, oDTL_ReadAccept;
    logic [W-1:0]  iDTL_ReadData;
`ifdef DTL_MASTER_LASTCHECK_EN
    logic          oProtocolError;
`endif

    dtl_master_interface dut (
        .iClk(iClk), .iReset(iReset),
        .iReqValid(iReqValid), .oReqAccept(oReqAccept), .iReqReadWrite(iReqReadWrite),
        .iReqAddress(iReqAddress), .iReqBlockSize(iReqBlockSize),
        .iWrValid(iWrValid), .oWrAccept(oWrAccept), .iWrData(iWrData), .iWrEnable(iWrEnable),
        .oRdValid(oRdValid), .iRdAccept(iRdAccept), .oRdData(oRdData), .oRdLast(oRdLast),
        .oBusy(oBusy), .oDone(oDone),
`ifdef DTL_MASTER_LASTCHECK_EN
        .oProtocolError(oProtocolError),
`endif
        .oDTL_CommandValid(oDTL_CommandValid), .iDTL_CommandAccept(iDTL_CommandAccept),
        .oDTL_Address(oDTL_Address), .oDTL_CommandReadWrite(oDTL_CommandReadWrite),
        .oDTL_BlockSize(oDTL_BlockSize), .oDTL_WriteValid(oDTL_WriteValid),
        .oDTL_WriteLast(oDTL_WriteLast), .iDTL_WriteAccept(iDTL_WriteAccept),
        .oDTL_WriteEnable(oDTL_WriteEnable), .oDTL_WriteData(oDTL_WriteData),
        .iDTL_ReadValid(iDTL_ReadValid), .iDTL_ReadLast(iDTL_ReadLast),
        .oDTL_ReadAccept(oDTL_ReadAccept), .iDTL_ReadData(iDTL_ReadData)
    );

    always #5 iClk = ~iClk;

    typedef struct packed {logic [AW-1:0] a; logic rw; logic [BW-1:0] sz;} cmd_t;
    typedef struct packed {logic [W-1:0] d; logic [NE-1:0] e; logic l;} wbeat_t;
    typedef struct packed {logic [W-1:0] d; logic l;} rbeat_t;

    cmd_t          exp_cmd[$];
    wbeat_t        exp_wr[$];
    rbeat_t        exp_rd[$];
    int            exp_done = 0;
    logic [W-1:0]  src_d[$];
    logic [NE-1:0] src_e[$];
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event expected=none", name);
    endtask

    function automatic bit coin(input int p);
        return $urandom_range(99) < p;
    endfunction

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic idle_inputs();
        iReqValid = 0; iReqReadWrite = 0; iReqAddress = '0; iReqBlockSize = '0;
        iWrValid = 0; iWrData = '0; iWrEnable = '0; iRdAccept = 0;
        iDTL_CommandAccept = 0; iDTL_WriteAccept = 0;
        iDTL_ReadValid = 0; iDTL_ReadLast = 0; iDTL_ReadData = '0;
    endtask

    task automatic fill_rand(input int size);
        src_d.delete(); src_e.delete();
        for (int i = 0; i <= size; i++) begin
            src_d.push_back($urandom);
            src_e.push_back(NE'($urandom));
        end
    endtask

    task automatic wait_accept();
        int n = 0;
        while (!oReqAccept && n < 100) begin
            step();
            n++;
        end
        if (!oReqAccept) fail_evt("req_accept_timeout");
    endtask

    task automatic apply_reset();
        idle_inputs();
        iReset = 1;
        exp_cmd.delete(); exp_wr.delete(); exp_rd.delete(); exp_done = 0;
        step();
        iReset = 0;
    endtask

    task automatic post_done(input bit fin, input string tag);
        idle_inputs();
        if (!fin) begin
            fail_evt({tag, "_timeout"});
            return;
        end
        chk({tag, "_req_accept_on_done"}, 64'(oReqAccept), 64'(0));
        step();
        chk({tag, "_busy_after_done"}, 64'(oBusy), 64'(0));
        chk({tag, "_done_single"}, 64'(oDone), 64'(0));
        chk({tag, "_req_accept_after"}, 64'(oReqAccept), 64'(1));
        chk({tag, "_scoreboard_drained"},
            64'(exp_cmd.size() + exp_wr.size() + exp_rd.size() + exp_done), 64'(0));
    endtask

    task automatic issue(input logic [AW-1:0] addr, input bit rw, input int size);
        wait_accept();
        iReqValid = 1; iReqReadWrite = rw; iReqAddress = addr; iReqBlockSize = BW'(size);
        exp_cmd.push_back('{a: addr, rw: rw, sz: BW'(size)});
        exp_done++;
        step();
        iReqValid = 0;
        chk("cmd_latency", 64'(oDTL_CommandValid), 64'(1));
    endtask

    task automatic run_write(input logic [AW-1:0] addr, input int size, input int pv,
                             input int pa, input int abort_at);
        int li = 0;
        int hs = 0;
        int cyc = 0;
        bit fin = 0;
        for (int i = 0; i <= size; i++)
            exp_wr.push_back('{d: src_d[i], e: src_e[i], l: (i == size)});
        issue(addr, 1'b0, size);
        while (!fin && cyc < 2000) begin
            iReqValid = coin(20); iReqAddress = $urandom; iReqReadWrite = coin(50);
            iDTL_CommandAccept = oDTL_CommandValid && coin(pa);
            iWrValid  = coin(pv);
            iWrData   = (li <= size) ? src_d[li] : $urandom;
            iWrEnable = (li <= size) ? src_e[li] : NE'($urandom);
            iDTL_WriteAccept = oDTL_WriteValid && coin(pa);
            #3;
            chk("req_accept_busy", 64'(oReqAccept), 64'(0));
            if (iWrValid && oWrAccept) begin
                if (li > size) fail_evt("wr_accept_overrun");
                else li++;
            end
            if (oDTL_WriteValid && iDTL_WriteAccept) hs++;
            step();
            cyc++;
            if (abort_at >= 0 && hs == abort_at) begin
                apply_reset();
                chk("rst_write_valid", 64'(oDTL_WriteValid), 64'(0));
                chk("rst_write_last", 64'(oDTL_WriteLast), 64'(0));
                chk("rst_cmd_valid", 64'(oDTL_CommandValid), 64'(0));
                chk("rst_busy", 64'(oBusy), 64'(0));
                chk("rst_done", 64'(oDone), 64'(0));
                chk("rst_address", 64'(oDTL_Address), 64'(0));
                chk("rst_wdata", 64'({oDTL_WriteData, oDTL_WriteEnable}), 64'(0));
                step();
                chk("rst_no_done_later", 64'(oDone), 64'(0));
                return;
            end
            if (oDone) fin = 1;
        end
        post_done(fin, "wr");
    endtask

    task automatic run_read(input logic [AW-1:0] addr, input int size, input int pv,
                            input int pa, input int bad_last);
        int ri = 0;
        int cyc = 0;
        bit fin = 0;
        for (int i = 0; i <= size; i++)
            exp_rd.push_back('{d: src_d[i], l: (i == size)});
        issue(addr, 1'b1, size);
        while (!fin && cyc < 2000) begin
            iReqValid = coin(20); iReqAddress = $urandom; iReqReadWrite = coin(50);
            iDTL_CommandAccept = oDTL_CommandValid && coin(pa);
            iDTL_ReadValid = !oDTL_CommandValid && (ri <= size) && coin(pv);
            iDTL_ReadData  = (ri <= size) ? src_d[ri] : $urandom;
            iDTL_ReadLast  = iDTL_ReadValid && (ri == size || ri == bad_last);
            iRdAccept      = coin(pa);
            #3;
            chk("req_accept_busy", 64'(oReqAccept), 64'(0));
            if (iDTL_ReadValid && oDTL_ReadAccept) ri++;
            step();
            cyc++;
            if (oDone) fin = 1;
        end
        post_done(fin, "rd");
    endtask

    // scoreboard monitor, sampled on the falling edge away from the active edge
    always @(negedge iClk) begin
        cmd_t   c;
        wbeat_t wb;
        rbeat_t rb;
        if (iReset === 1'b0) begin
            if (oDTL_CommandValid && iDTL_CommandAccept) begin
                if (exp_cmd.size() == 0) fail_evt("unexpected_cmd");
                else begin
                    c = exp_cmd.pop_front();
                    chk("dtl_cmd", 64'({oDTL_Address, oDTL_CommandReadWrite, oDTL_BlockSize}), 64'(c));
                end
            end
            if (oDTL_WriteValid && iDTL_WriteAccept) begin
                if (exp_wr.size() == 0) fail_evt("unexpected_wr_beat");
                else begin
                    wb = exp_wr.pop_front();
                    chk("dtl_wr_beat", 64'({oDTL_WriteData, oDTL_WriteEnable, oDTL_WriteLast}), 64'(wb));
                end
            end
            if (oRdValid && iRdAccept) begin
                if (exp_rd.size() == 0) fail_evt("unexpected_rd_word");
                else begin
                    rb = exp_rd.pop_front();
                    chk("local_rd_word", 64'({oRdData, oRdLast}), 64'(rb));
                end
            end
            if (oDone) begin
                chk("done_expected", 64'(exp_done > 0), 64'(1));
                if (exp_done > 0) exp_done--;
            end
            chk("no_rd_wr_overlap", 64'(oDTL_ReadAccept && oDTL_WriteValid), 64'(0));
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        iReset = 1;
        repeat (3) step();
        iReset = 0;
        iDTL_ReadValid = 1; iRdAccept = 1;
        #1;
        chk("rst_req_accept", 64'(oReqAccept), 64'(1));
        chk("rst_busy0", 64'(oBusy), 64'(0));
        chk("rst_cmd_fields", 64'({oDTL_CommandValid, oDTL_Address, oDTL_BlockSize}), 64'(0));
        chk("rst_wr_fields", 64'({oDTL_WriteValid, oDTL_WriteLast, oDTL_WriteData}), 64'(0));
        chk("idle_rd_gated", 64'({oRdValid, oDTL_ReadAccept}), 64'(0));
        chk("rst_done0", 64'(oDone), 64'(0));
        idle_inputs();
        step();

        // single-beat write
        src_d.delete(); src_e.delete();
        src_d.push_back(32'hDEADBEEF); src_e.push_back(4'hF);
        run_write(32'h100, 0, 100, 100, -1);
        // four-beat write with local gaps and slave stalls
        fill_rand(3);
        run_write(32'h200, 3, 50, 40, -1);
        // three-beat read with local back-pressure
        src_d.delete(); src_d.push_back(32'h1); src_d.push_back(32'h2); src_d.push_back(32'h3);
        run_read(32'h40, 2, 100, 40, -1);
        // read then write right after the completion pulse
        fill_rand(0);
        run_read(32'h80, 0, 100, 100, -1);
        fill_rand(0);
        run_write(32'h84, 0, 100, 100, -1);
        // reset mid-burst, then a fresh transaction
        fill_rand(3);
        run_write(32'h300, 3, 100, 100, 2);
        fill_rand(1);
        run_write(32'h304, 1, 80, 80, -1);
        // maximum burst length both ways
        fill_rand(31);
        run_write(32'h1000, 31, 90, 90, -1);
        fill_rand(31);
        run_read(32'h2000, 31, 90, 90, -1);

        for (int t = 0; t < 40; t++) begin
            int size;
            size = coin(15) ? 31 : int'($urandom_range(0, 7));
            fill_rand(size);
            if (coin(50)) run_read($urandom, size, $urandom_range(30, 100), $urandom_range(30, 100), -1);
            else run_write($urandom, size, $urandom_range(30, 100), $urandom_range(30, 100), -1);
        end

`ifdef DTL_MASTER_LASTCHECK_EN
        chk("perr_clean_traffic", 64'(oProtocolError), 64'(0));
        fill_rand(3);
        run_read(32'h500, 3, 100, 100, 1);
        chk("perr_set", 64'(oProtocolError), 64'(1));
        fill_rand(1);
        run_write(32'h600, 1, 100, 100, -1);
        chk("perr_sticky", 64'(oProtocolError), 64'(1));
        apply_reset();
        chk("perr_cleared", 64'(oProtocolError), 64'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
